// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the VGA scan-out reader
// and two round-robin writers (wr0 tile painter, wr1 sprite painter).
// Display owns the port whenever disp_active is high; writers use blanking.
// Optional feature: define VRAM_ARB_STALL_CNT_EN to add the stall_cnt output
// (per-line count of edges where a writer request went ungranted).
module vram_arbiter #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 307200
) (
    input  logic              clk_25mhz,
    input  logic              Rst_n,
    input  logic              disp_active,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              wr0_req,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ack,
    input  logic              wr1_req,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ack,
    output logic              wr_err,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_din
`ifdef VRAM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_WR0  = 2'd2,
        ST_WR1  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_rr_ptr;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_err;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_rr_nxt;
    logic              w_ack0_nxt;
    logic              w_ack1_nxt;
    logic              w_err_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_din_nxt;

    // A writer whose ack is currently high is retiring its beat; mask it so the
    // same beat is never written twice. Registered owner WRn equals wrN_ack=1.
    assign w_elig0 = wr0_req && (r_state != ST_WR0);
    assign w_elig1 = wr1_req && (r_state != ST_WR1);

    // Owner register
    always_ff @(posedge clk_25mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next owner: display first, then round-robin among eligible writers
    always_comb begin
        w_next_state = ST_IDLE;
        if (disp_active) begin
            w_next_state = ST_DISP;
        end else if (w_elig0 && w_elig1) begin
            w_next_state = r_rr_ptr ? ST_WR1 : ST_WR0;
        end else if (w_elig0) begin
            w_next_state = ST_WR0;
        end else if (w_elig1) begin
            w_next_state = ST_WR1;
        end
    end

    // Next values of the registered VRAM-side outputs for the chosen owner
    always_comb begin
        w_addr_nxt = r_addr;
        w_din_nxt  = r_din;
        w_we_nxt   = 1'b0;
        w_ack0_nxt = 1'b0;
        w_ack1_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        w_rr_nxt   = r_rr_ptr;
        case (w_next_state)
            ST_DISP: begin
                w_addr_nxt = disp_addr;
            end
            ST_WR0: begin
                w_addr_nxt = wr0_addr;
                w_din_nxt  = wr0_data;
                w_ack0_nxt = 1'b1;
                w_we_nxt   = (wr0_addr <  ADDR_W'(DEPTH));
                w_err_nxt  = (wr0_addr >= ADDR_W'(DEPTH));
                w_rr_nxt   = 1'b1;
            end
            ST_WR1: begin
                w_addr_nxt = wr1_addr;
                w_din_nxt  = wr1_data;
                w_ack1_nxt = 1'b1;
                w_we_nxt   = (wr1_addr <  ADDR_W'(DEPTH));
                w_err_nxt  = (wr1_addr >= ADDR_W'(DEPTH));
                w_rr_nxt   = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Output and round-robin pointer registers
    always_ff @(posedge clk_25mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_addr   <= '0;
            r_din    <= '0;
            r_we     <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err    <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else begin
            r_addr   <= w_addr_nxt;
            r_din    <= w_din_nxt;
            r_we     <= w_we_nxt;
            r_ack0   <= w_ack0_nxt;
            r_ack1   <= w_ack1_nxt;
            r_err    <= w_err_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    assign vram_addr = r_addr;
    assign vram_din  = r_din;
    assign vram_we   = r_we;
    assign wr0_ack   = r_ack0;
    assign wr1_ack   = r_ack1;
    assign wr_err    = r_err;

`ifdef VRAM_ARB_STALL_CNT_EN
    logic [STALL_W-1:0] r_stall_cnt;
    logic               w_stall;
    logic               w_disp_rise;

    assign w_stall     = (wr0_req && (w_next_state != ST_WR0)) ||
                         (wr1_req && (w_next_state != ST_WR1));
    // Owner was not DISP last edge, so a high disp_active now is a rising edge
    assign w_disp_rise = disp_active && (r_state != ST_DISP);

    // Per-line stall counter: restarts on display rise, saturates at all-ones
    always_ff @(posedge clk_25mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_disp_rise) begin
            r_stall_cnt <= STALL_W'(w_stall);
        end else if (w_stall && (r_stall_cnt != {STALL_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter.
module tb_vram_arbiter;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 12;

    logic              clk_25mhz = 1'b0;
    logic              Rst_n;
    logic              disp_active;
    logic [ADDR_W-1:0] disp_addr;
    logic              wr0_req;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr0_ack;
    logic              wr1_req;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic              wr1_ack;
    logic              wr_err;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [DATA_W-1:0] vram_din;
`ifdef VRAM_ARB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    vram_arbiter dut (
        .clk_25mhz  (clk_25mhz),
        .Rst_n      (Rst_n),
        .disp_active(disp_active),
        .disp_addr  (disp_addr),
        .wr0_req    (wr0_req),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr0_ack    (wr0_ack),
        .wr1_req    (wr1_req),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .wr1_ack    (wr1_ack),
        .wr_err     (wr_err),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_din   (vram_din)
`ifdef VRAM_ARB_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic a0, input logic a1,
                              input logic we, input logic [31:0] addr, input logic [31:0] din);
        check({tag, ".ack0"}, 32'(wr0_ack), 32'(a0));
        check({tag, ".ack1"}, 32'(wr1_ack), 32'(a1));
        check({tag, ".we"},   32'(vram_we), 32'(we));
        check({tag, ".addr"}, 32'(vram_addr), addr);
        if (we) check({tag, ".din"}, 32'(vram_din), din);
    endtask

    initial begin
        Rst_n = 1'b0; disp_active = 1'b0; disp_addr = '0;
        wr0_req = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_req = 1'b0; wr1_addr = '0; wr1_data = '0;
        tick(); tick();
        Rst_n = 1'b1;

        // Reset mid-write: start a wr0 beat, then reset while it is acked
        wr0_req = 1'b1; wr0_addr = 19'd9; wr0_data = 12'h999;
        tick();
        check("pre_rst.ack0", 32'(wr0_ack), 32'd1);
        Rst_n = 1'b0;
        #1;
        check_beat("rst", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("rst.din", 32'(vram_din), 32'd0);
        check("rst.err", 32'(wr_err), 32'd0);
        wr0_addr = 19'd5; wr0_data = 12'h055;
        wr1_req = 1'b1; wr1_addr = 19'd7; wr1_data = 12'h077;
        tick();
        check("rst_hold.ack0", 32'(wr0_ack), 32'd0);
        Rst_n = 1'b1;
        tick();
        check_beat("first_grant", 1'b1, 1'b0, 1'b1, 32'd5, 32'h055);
        wr0_req = 1'b0;
        tick();
        check_beat("second_grant", 1'b0, 1'b1, 1'b1, 32'd7, 32'h077);
        wr1_req = 1'b0;
        tick();
        check_beat("idle_hold", 1'b0, 1'b0, 1'b0, 32'd7, 32'd0);

        // Display priority over a pending write
        disp_active = 1'b1; disp_addr = 19'h00123;
        wr0_req = 1'b1; wr0_addr = 19'h00200; wr0_data = 12'hABC;
        tick();
        check_beat("disp", 1'b0, 1'b0, 1'b0, 32'h123, 32'd0);
        check("disp.err", 32'(wr_err), 32'd0);
        disp_active = 1'b0;
        tick();
        check_beat("after_disp", 1'b1, 1'b0, 1'b1, 32'h200, 32'hABC);
        wr0_req = 1'b0;
        tick();

        // Single writer stream: one beat every second cycle
        wr1_req = 1'b1; wr1_addr = 19'd100; wr1_data = 12'h500;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_beat($sformatf("single%0d", i), 1'b0, 1'b1, 1'b1, 32'(100 + i), 32'(12'h500 + i));
            if (i < 4) begin
                wr1_addr = ADDR_W'(101 + i);
                wr1_data = DATA_W'(12'h501 + i);
            end else begin
                wr1_req = 1'b0;
            end
            tick();
            check_beat($sformatf("single%0d_gap", i), 1'b0, 1'b0, 1'b0, 32'(100 + i), 32'd0);
        end

        // Two writers in blanking: strict alternation, one write per cycle
        wr0_req = 1'b1; wr0_addr = 19'd200; wr0_data = 12'h0A0;
        wr1_req = 1'b1; wr1_addr = 19'd300; wr1_data = 12'h0B0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if ((k % 2) == 0) begin
                check_beat($sformatf("rr%0d", k), 1'b1, 1'b0, 1'b1, 32'(200 + k / 2), 32'(12'h0A0 + k / 2));
                if (k / 2 < 3) begin
                    wr0_addr = ADDR_W'(200 + k / 2 + 1);
                    wr0_data = DATA_W'(12'h0A0 + k / 2 + 1);
                end else begin
                    wr0_req = 1'b0;
                end
            end else begin
                check_beat($sformatf("rr%0d", k), 1'b0, 1'b1, 1'b1, 32'(300 + k / 2), 32'(12'h0B0 + k / 2));
                if (k / 2 < 3) begin
                    wr1_addr = ADDR_W'(300 + k / 2 + 1);
                    wr1_data = DATA_W'(12'h0B0 + k / 2 + 1);
                end else begin
                    wr1_req = 1'b0;
                end
            end
        end
        tick();

        // Address range boundary
        wr0_req = 1'b1; wr0_addr = 19'd307200; wr0_data = 12'hBAD;
        tick();
        check_beat("oob", 1'b1, 1'b0, 1'b0, 32'd307200, 32'd0);
        check("oob.err", 32'(wr_err), 32'd1);
        wr0_req = 1'b0;
        tick();
        check("oob_after.err", 32'(wr_err), 32'd0);
        wr0_req = 1'b1; wr0_addr = 19'd307199; wr0_data = 12'h0C0;
        tick();
        check_beat("last_word", 1'b1, 1'b0, 1'b1, 32'd307199, 32'h0C0);
        check("last_word.err", 32'(wr_err), 32'd0);
        wr0_req = 1'b0;
        tick();

`ifdef VRAM_ARB_STALL_CNT_EN
        // Stall counter: one count per display-owned edge with a pending request
        disp_active = 1'b1; disp_addr = 19'd1;
        wr0_req = 1'b1; wr0_addr = 19'd50; wr0_data = 12'h050;
        for (int i = 0; i < 10; i++) tick();
        check("stall.cnt10", 32'(stall_cnt), 32'd10);
        disp_active = 1'b0;
        tick();
        check("stall.grant_ack0", 32'(wr0_ack), 32'd1);
        check("stall.hold", 32'(stall_cnt), 32'd10);
        wr0_req = 1'b0;
        tick();
        disp_active = 1'b1;
        tick();
        check("stall.clear", 32'(stall_cnt), 32'd0);
        disp_active = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
